// File: rtl/div8x4_pkg.sv
// Shared widths, step count and FSM state type for the div8x4 sequential divider.
package div8x4_pkg;

    localparam int unsigned DIVIDEND_W = 8;
    localparam int unsigned DIVISOR_W  = 4;
    localparam int unsigned REM_W      = 5;
    localparam int unsigned STEP_COUNT = 8;
    localparam int unsigned CNT_W      = 3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef logic [DIVIDEND_W-1:0] dividend_t;
    typedef logic [DIVISOR_W-1:0]  divisor_t;
    typedef logic [REM_W-1:0]      prem_t;
    typedef logic [CNT_W-1:0]      cnt_t;

endpackage

// File: rtl/div8x4_if.sv
// Handshake and result bundle of div8x4; master launches divisions, slave is the divider.
interface div8x4_if;
    import div8x4_pkg::*;

    logic      start;
    dividend_t dividend;
    divisor_t  divisor;
    dividend_t quotient;
    divisor_t  remainder;
    logic      done_flag;
    logic      busy;
    logic      div_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, done_flag, busy, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, done_flag, busy, div_zero
    );

endinterface

// File: rtl/div8x4_div_step.sv
// div_step: one combinational restoring-division step (shift in a bit, trial subtract).
module div_step
    import div8x4_pkg::*;
(
    input  prem_t    rem_in,
    input  logic     next_bit,
    input  divisor_t divisor,
    output prem_t    rem_out,
    output logic     q_bit
);

    logic [REM_W:0] shifted;

    // The full-width compare equals the 5-bit rule: rem_in[4] is only ever set when divisor is 0.
    always_comb begin
        shifted = {rem_in, next_bit};
        q_bit   = 1'b0;
        rem_out = shifted[REM_W-1:0];
        if (shifted >= {2'b00, divisor}) begin
            q_bit   = 1'b1;
            rem_out = shifted[REM_W-1:0] - {1'b0, divisor};
        end
    end

endmodule

// File: rtl/div8x4.sv
// div8x4: 8-bit / 4-bit sequential restoring divider, one quotient bit per CALC cycle.
// Optional macro DIV8X4_DIVZERO_EN: early exit with div_zero flag on a zero divisor.
module div8x4
    import div8x4_pkg::*;
(
    input logic     clk,
    input logic     reset_a,
    div8x4_if.slave bus
);

    localparam cnt_t LAST_CNT = cnt_t'(STEP_COUNT - 1);

    state_t    state, state_n;
    dividend_t shift_q;
    divisor_t  dsr_q;
    prem_t     rem_q;
    prem_t     rem_nx;
    cnt_t      cnt_q;
    dividend_t quot_q;
    divisor_t  rem_out_q;
    logic      q_bit;
    logic      accept;
    logic      last_step;
    logic      zero_exit;

    div_step u_step (
        .rem_in   (rem_q),
        .next_bit (shift_q[DIVIDEND_W-1]),
        .divisor  (dsr_q),
        .rem_out  (rem_nx),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk) begin
        if (reset_a) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        last_step = 1'b0;
        zero_exit = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_n = CALC;
                end
            end
            CALC: begin
                if (cnt_q == LAST_CNT) begin
                    last_step = 1'b1;
                    state_n   = DONE;
                end
`ifdef DIV8X4_DIVZERO_EN
                if (cnt_q == '0 && dsr_q == '0) begin
                    zero_exit = 1'b1;
                    last_step = 1'b0;
                    state_n   = DONE;
                end
`endif
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // The working dividend register doubles as the quotient shift register.
    always_ff @(posedge clk) begin
        if (reset_a) begin
            shift_q   <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            quot_q    <= '0;
            rem_out_q <= '0;
        end else if (accept) begin
            shift_q <= bus.dividend;
            dsr_q   <= bus.divisor;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else if (zero_exit) begin
            quot_q    <= '1;
            rem_out_q <= shift_q[DIVISOR_W-1:0];
        end else if (state == CALC) begin
            shift_q <= {shift_q[DIVIDEND_W-2:0], q_bit};
            rem_q   <= rem_nx;
            cnt_q   <= cnt_q + cnt_t'(1);
            if (last_step) begin
                quot_q    <= {shift_q[DIVIDEND_W-2:0], q_bit};
                rem_out_q <= rem_nx[DIVISOR_W-1:0];
            end
        end
    end

`ifdef DIV8X4_DIVZERO_EN
    logic dz_q;

    always_ff @(posedge clk) begin
        if (reset_a) begin
            dz_q <= 1'b0;
        end else if (accept) begin
            dz_q <= 1'b0;
        end else if (zero_exit) begin
            dz_q <= 1'b1;
        end
    end

    assign bus.div_zero = dz_q;
`else
    assign bus.div_zero = 1'b0;
`endif

    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_out_q;
    assign bus.done_flag = (state == DONE);
    assign bus.busy      = (state != IDLE);

endmodule

// File: doc/div8x4.md
DIV8X4 -- requirements
Module: div8x4

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed and taken from div8x4_pkg.
REQ-002 clk  input  1  Single clock; all state updates on its rising edge.
REQ-003 reset_a  input  1  Reset; synchronous, active-high.
REQ-004 start  input  1  Start request; sampled only in IDLE.
REQ-005 dividend  input  8  Unsigned dividend; sampled on the edge that accepts start.
REQ-006 divisor  input  4  Unsigned divisor; sampled on the edge that accepts start.
REQ-007 quotient  output  8  Registered unsigned quotient.
REQ-008 remainder  output  4  Registered unsigned remainder.
REQ-009 done_flag  output  1  One-cycle completion pulse.
REQ-010 busy  output  1  High in CALC and DONE; low in IDLE.
REQ-011 div_zero  output  1  Divide-by-zero indication; registered.

Function
REQ-012 The block SHALL be a sequential restoring divider computing dividend / divisor and producing one quotient bit per CALC cycle, MSB first.
REQ-013 The FSM SHALL have the states IDLE, CALC and DONE.
REQ-014 IDLE -> CALC on a rising edge with start=1: latch the operands, clear the partial remainder, set step count to 0, clear div_zero.
REQ-015 Each CALC edge SHALL perform one step: R = {R[3:0], next dividend bit}; if R >= {0,divisor}, then R = R - divisor and the quotient bit is 1; otherwise the quotient bit is 0.
REQ-016 The partial remainder SHALL be 5 bits wide; the step count SHALL be 3 bits wide and wrap from 7 to 0 on the 8th step.
REQ-017 CALC -> DONE SHALL occur on the 8th CALC edge; quotient and remainder are updated on that edge.
REQ-018 done_flag SHALL be 1 exactly while the state is DONE.
REQ-019 DONE -> IDLE SHALL occur on the next edge, unconditionally.
REQ-020 Latency: start accepted at edge E0 puts done_flag high in the cycle after E8 (9 cycles start-to-done).
REQ-021 quotient, remainder and div_zero SHALL hold their values from DONE until the next accepted start.
REQ-022 start SHALL be ignored in CALC and DONE; operand changes after acceptance SHALL have no effect on the result.
REQ-023 start held high continuously SHALL re-launch on the first IDLE edge after each DONE.
REQ-024 divisor = 0 without early exit SHALL run 8 steps and yield quotient = 8'hFF, remainder = dividend[3:0].

Reset
REQ-025 reset_a=1 at a rising edge SHALL force IDLE and clear quotient, remainder, done_flag, busy, div_zero and the step count to 0.
REQ-026 Reset SHALL take precedence over start in the same cycle.
REQ-027 Reset in CALC SHALL abort the operation without a done_flag pulse.

Configuration
REQ-028 Macro DIV8X4_DIVZERO_EN defined: divisor = 0 at acceptance SHALL go IDLE -> DONE at E1 with quotient = 8'hFF, remainder = dividend[3:0] and div_zero = 1.
REQ-029 Macro DIV8X4_DIVZERO_EN undefined: div_zero SHALL be tied to 0 and divisor = 0 SHALL follow REQ-024 with normal 9-cycle latency.

Structure
REQ-030 div8x4_pkg SHALL hold the state enum (IDLE/CALC/DONE), the width constants (8, 4, remainder width 5) and the step count constant of 8.
REQ-031 A combinational sub-module div_step SHALL implement one restoring step: inputs partial remainder, next bit and divisor; outputs the new remainder and the quotient bit.

Verification
REQ-032 200 / 7 -> quotient 28, remainder 4, done_flag one cycle, 9 cycles after start.
REQ-033 255 / 15 -> quotient 17, remainder 0; 5 / 9 -> quotient 0, remainder 5.
REQ-034 0xA5 / 0 -> quotient 0xFF, remainder 5; with the macro: div_zero=1, done 2 cycles after start; without the macro: div_zero=0, done after 9 cycles.
REQ-035 start pulsed with new operands at CALC step 3 -> ignored; the first result is unchanged and busy stays high.
REQ-036 reset_a asserted at step 5 -> next cycle IDLE, all outputs 0, no done_flag; a following 100 / 3 -> quotient 33, remainder 1.
